// File: rtl/mac_out_collector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_out_collector_pkg                                              |
// | Shared sizing defaults for the mac_array output collector.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mac_out_collector_pkg;

  localparam int DEF_COL     = 8;
  localparam int DEF_PSUM_BW = 16;
  localparam int DEF_DEPTH   = 8;

  // Pointer width carries one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W = ptr_w(DEF_DEPTH);

endpackage : mac_out_collector_pkg
`default_nettype wire

// File: rtl/mac_out_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_out_collector_if                                               |
// | Column push bus from the array and row pop bus to the reader.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mac_out_collector_if
  import mac_out_collector_pkg::*;
#(
  parameter int COL     = DEF_COL,
  parameter int PSUM_BW = DEF_PSUM_BW
);

  logic [PSUM_BW*COL-1:0] in;
  logic [COL-1:0]         wr;
  logic                   rd;
  logic [PSUM_BW*COL-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   overflow;

  modport master (
    output in,
    output wr,
    output rd,
    input  out,
    input  o_valid,
    input  o_full,
    input  o_ready,
    input  overflow
  );

  modport slave (
    input  in,
    input  wr,
    input  rd,
    output out,
    output o_valid,
    output o_full,
    output o_ready,
    output overflow
  );

endinterface : mac_out_collector_if
`default_nettype wire

// File: rtl/mac_out_collector_col_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | col_fifo                                                           |
// | Single-column show-ahead FIFO with wrap-bit pointers.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module col_fifo
  import mac_out_collector_pkg::*;
#(
  parameter int WIDTH = DEF_PSUM_BW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             wr,
  input  wire logic             rd,
  input  wire logic [WIDTH-1:0] in,
  output logic      [WIDTH-1:0] out,
  output logic                  empty,
  output logic                  full
);

  localparam int AW    = ptr_w(DEPTH);
  localparam int IDX_W = AW - 1;

  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic push;
  logic pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                 (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  // A same-cycle pop frees the slot a push into a full FIFO needs.
  assign pop  = rd && !empty;
  assign push = wr && (!full || pop);

  assign out = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally left out of reset; stale entries are unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule : col_fifo
`default_nettype wire

// File: rtl/mac_out_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_out_collector                                                  |
// | Per-column FIFOs re-aligning skewed array outputs into rows.       |
// | Optional ReLU on the read mux: define OFIFO_RELU_EN.               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mac_out_collector
  import mac_out_collector_pkg::*;
#(
  parameter int COL     = DEF_COL,
  parameter int PSUM_BW = DEF_PSUM_BW,
  parameter int DEPTH   = DEF_DEPTH
) (
  input wire logic            clk,
  input wire logic            reset,
  mac_out_collector_if.slave  bus
);

  logic [COL-1:0]         col_empty;
  logic [COL-1:0]         col_full;
  logic [COL-1:0]         col_drop;
  logic [PSUM_BW*COL-1:0] head_row;
  logic [PSUM_BW*COL-1:0] out_row;
  logic                   row_valid;
  logic                   pop;
  logic                   overflow_q;
  logic                   overflow_d;

  assign row_valid = &(~col_empty);
  assign pop       = bus.rd && row_valid;

  generate
    for (genvar c = 0; c < COL; c++) begin : g_col
      col_fifo #(
        .WIDTH (PSUM_BW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.wr[c]),
        .rd    (pop),
        .in    (bus.in[PSUM_BW*c +: PSUM_BW]),
        .out   (head_row[PSUM_BW*c +: PSUM_BW]),
        .empty (col_empty[c]),
        .full  (col_full[c])
      );
    end
  endgenerate

  assign col_drop = bus.wr & col_full & ~{COL{pop}};

  always_comb begin
    overflow_d = overflow_q | (|col_drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    out_row = '0;
    if (row_valid) begin
      for (int c = 0; c < COL; c++) begin
        out_row[PSUM_BW*c +: PSUM_BW] = head_row[PSUM_BW*c +: PSUM_BW];
`ifdef OFIFO_RELU_EN
        if (head_row[PSUM_BW*c + PSUM_BW - 1]) begin
          out_row[PSUM_BW*c +: PSUM_BW] = '0;
        end
`else
`endif
      end
    end
  end

  assign bus.out      = out_row;
  assign bus.o_valid  = row_valid;
  assign bus.o_full   = |col_full;
  assign bus.o_ready  = ~(|col_full);
  assign bus.overflow = overflow_q;

endmodule : mac_out_collector
`default_nettype wire

// File: tb/tb_mac_out_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mac_out_collector                                               |
// | Directed stimulus with a list-based reference model.               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mac_out_collector;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mac_out_collector_if #(.COL(COL), .PSUM_BW(BW)) bus();

  mac_out_collector #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each column is an ordered list of stored values.
  logic [BW-1:0] mdata [COL][DEP];
  int            mcnt  [COL];
  logic          movf;

  initial begin
    for (int c = 0; c < COL; c++) mcnt[c] = 0;
    movf = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int c = 0; c < COL; c++) mcnt[c] = 0;
        movf = 1'b0;
      end else begin
        logic all_ne;
        logic p;
        all_ne = 1'b1;
        for (int c = 0; c < COL; c++) if (mcnt[c] == 0) all_ne = 1'b0;
        p = bus.rd && all_ne;
        for (int c = 0; c < COL; c++) begin
          if (p) begin
            for (int k = 0; k < DEP - 1; k++) mdata[c][k] = mdata[c][k+1];
            mcnt[c] = mcnt[c] - 1;
          end
          if (bus.wr[c]) begin
            if (mcnt[c] < DEP) begin
              mdata[c][mcnt[c]] = bus.in[BW*c +: BW];
              mcnt[c] = mcnt[c] + 1;
            end else begin
              movf = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic          ev;
        logic          ef;
        logic [127:0]  eo;
        logic [BW-1:0] h;
        ev = 1'b1;
        ef = 1'b0;
        eo = '0;
        for (int c = 0; c < COL; c++) begin
          if (mcnt[c] == 0) ev = 1'b0;
          if (mcnt[c] == DEP) ef = 1'b1;
        end
        if (ev) begin
          for (int c = 0; c < COL; c++) begin
            h = mdata[c][0];
`ifdef OFIFO_RELU_EN
            if (h[BW-1]) h = '0;
`endif
            eo[BW*c +: BW] = h;
          end
        end
        chk("model_o_valid", {127'd0, bus.o_valid}, {127'd0, ev});
        chk("model_o_full", {127'd0, bus.o_full}, {127'd0, ef});
        chk("model_o_ready", {127'd0, bus.o_ready}, {127'd0, ~ef});
        chk("model_overflow", {127'd0, bus.overflow}, {127'd0, movf});
        chk("model_out", bus.out, eo);
      end
    end
  end

  task automatic step(input logic [COL-1:0] w, input logic r);
    bus.wr = w;
    bus.rd = r;
    @(posedge clk);
    #1;
    bus.wr = '0;
    bus.rd = 1'b0;
  endtask

  initial begin
    bus.in = '0;
    bus.wr = '0;
    bus.rd = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_o_valid", {127'd0, bus.o_valid}, 128'd0);
    chk("reset_o_ready", {127'd0, bus.o_ready}, 128'd1);
    chk("reset_o_full", {127'd0, bus.o_full}, 128'd0);
    chk("reset_overflow", {127'd0, bus.overflow}, 128'd0);
    chk("reset_out", bus.out, 128'd0);
    reset = 1'b0;

    // Single aligned row, values 1..8.
    for (int c = 0; c < COL; c++) bus.in[BW*c +: BW] = 16'(c + 1);
    step(8'hFF, 1'b0);
    chk("t1_o_valid", {127'd0, bus.o_valid}, 128'd1);
    chk("t1_out", bus.out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    step(8'h00, 1'b1);
    chk("t1_pop_o_valid", {127'd0, bus.o_valid}, 128'd0);

    // Skewed columns align only after the last one lands.
    for (int c = 0; c < COL; c++) bus.in[BW*c +: BW] = 16'h0100 + 16'(c);
    for (int c = 0; c < COL; c++) begin
      step(8'(1 << c), 1'b0);
      if (c < COL - 1) chk("t2_skew_o_valid", {127'd0, bus.o_valid}, 128'd0);
    end
    chk("t2_aligned_o_valid", {127'd0, bus.o_valid}, 128'd1);
    chk("t2_aligned_out", bus.out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    step(8'h00, 1'b1);

    // Column 0 fills, then one push too many.
    for (int i = 0; i < DEP; i++) begin
      bus.in[BW-1:0] = 16'h0200 + 16'(i);
      step(8'h01, 1'b0);
    end
    chk("t3_o_full", {127'd0, bus.o_full}, 128'd1);
    chk("t3_o_ready", {127'd0, bus.o_ready}, 128'd0);
    chk("t3_no_ovf_yet", {127'd0, bus.overflow}, 128'd0);
    step(8'h01, 1'b0);
    chk("t3_overflow", {127'd0, bus.overflow}, 128'd1);
    reset = 1'b1;
    #1;
    chk("t3_reset_overflow", {127'd0, bus.overflow}, 128'd0);
    chk("t3_reset_o_ready", {127'd0, bus.o_ready}, 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // All columns full, then push and pop together.
    for (int r = 0; r <= DEP; r++) begin
      for (int c = 0; c < COL; c++) bus.in[BW*c +: BW] = 16'h1000 + 16'(r * 16 + c);
      if (r < DEP) step(8'hFF, 1'b0);
    end
    chk("t4_full", {127'd0, bus.o_full}, 128'd1);
    chk("t4_head_before", {112'd0, bus.out[BW-1:0]}, 128'h1000);
    step(8'hFF, 1'b1);
    chk("t4_head_after", {112'd0, bus.out[BW-1:0]}, 128'h1010);
    chk("t4_still_full", {127'd0, bus.o_full}, 128'd1);
    chk("t4_no_overflow", {127'd0, bus.overflow}, 128'd0);
    for (int i = 0; i < DEP; i++) step(8'h00, 1'b1);
    chk("t4_drained", {127'd0, bus.o_valid}, 128'd0);

    // Pops while empty are ignored.
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1);
    chk("t5_empty_out", bus.out, 128'd0);
    chk("t5_empty_o_valid", {127'd0, bus.o_valid}, 128'd0);
    for (int c = 0; c < COL; c++) bus.in[BW*c +: BW] = 16'h0050 + 16'(c);
    step(8'hFF, 1'b0);
    chk("t5_row_out", bus.out, 128'h0057_0056_0055_0054_0053_0052_0051_0050);
    step(8'h00, 1'b1);

    // Negative psum on column 3.
    for (int c = 0; c < COL; c++) bus.in[BW*c +: BW] = 16'h0006;
    bus.in[BW*3 +: BW] = 16'h8005;
    step(8'hFF, 1'b0);
`ifdef OFIFO_RELU_EN
    chk("t6_col3", {112'd0, bus.out[BW*3 +: BW]}, 128'h0000);
`else
    chk("t6_col3", {112'd0, bus.out[BW*3 +: BW]}, 128'h8005);
`endif
    chk("t6_col0", {112'd0, bus.out[BW-1:0]}, 128'h0006);
    step(8'h00, 1'b1);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mac_out_collector
`default_nettype wire
